fifo_write_arbiter: RTL and testbench

//   Shares the single write port of the synchronous dual-port-RAM FIFO among NUM_REQ producers.

---
 rtl/fifo_arb_pkg.sv | 23 ++
 rtl/rr_priority_pick.sv | 39 +++
 rtl/fifo_write_arbiter.sv | 123 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state encoding and helper function for the FIFO write arbiter
package fifo_arb_pkg;

    // ST_IDLE: no owner, arbitration happens this cycle.
    // ST_GRANT: one producer owns the FIFO write port.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Ceiling log2, usable in parameter expressions; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational rotating-priority picker
//
// Ports:
//   req          in   N       request vector
//   last_winner  in   IDX_W   index granted most recently; search starts just above it
//   winner       out  IDX_W   index of the first set request found, wrapping modulo N
//   valid        out  1       at least one request is set
module rr_priority_pick
    import fifo_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = (clog2(N) < 1) ? 1 : clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_winner,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        valid  = 1'b0;
        // Walk from the farthest candidate back to the nearest so the
        // nearest set request is the one that sticks.
        for (int k = N; k >= 1; k--) begin
            idx = int'(last_winner) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                winner = IDX_W'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin, burst-bounded arbiter for a FIFO write port
//
// Ports:
//   clk              in   1                   rising-edge clock
//   reset_n          in   1                   synchronous active-low reset
//   req              in   NUM_REQ             per-producer word available
//   req_data         in   NUM_REQ*DATA_WIDTH  producer i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last         in   NUM_REQ             presented word ends the producer's burst
//   ack              out  NUM_REQ             one-hot, word of producer i accepted this cycle
//   grant            out  NUM_REQ             registered one-hot owner, 0 when idle
//   busy             out  1                   registered, high while a producer owns the port
//   fifo_full        in   1                   FIFO full flag
//   fifo_write       out  1                   FIFO write strobe
//   fifo_write_data  out  DATA_WIDTH          FIFO write data
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    input  logic                          fifo_full,
    output logic                          fifo_write,
    output logic [DATA_WIDTH-1:0]         fifo_write_data
);

    localparam int CNT_W = clog2(MAX_BURST + 1);
    localparam int IDX_W = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);

    state_t             state;
    logic [NUM_REQ-1:0] grant_q;
    logic               busy_q;
    logic [CNT_W-1:0]   burst_cnt;
    logic [IDX_W-1:0]   last_winner;

    logic [IDX_W-1:0]   pick_winner;
    logic               pick_valid;
    logic               owner_req;
    logic               owner_last;
    logic               xfer;
    logic               burst_end;
    logic               release_grant;

    rr_priority_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req         (req),
        .last_winner (last_winner),
        .winner      (pick_winner),
        .valid       (pick_valid)
    );

    // grant_q is one-hot, so masking with it selects the owner's bits
    // without needing a separate owner index.
    assign owner_req  = |(req & grant_q);
    assign owner_last = |(req_last & grant_q);

    // reset_n gates the strobe so a word in flight during reset is dropped.
    assign xfer       = reset_n & (state == ST_GRANT) & owner_req & ~fifo_full;
    assign burst_end  = (burst_cnt == CNT_W'(MAX_BURST - 1));
    assign release_grant = (xfer & (owner_last | burst_end)) | ~owner_req;

    assign fifo_write = xfer;
    assign ack        = xfer ? grant_q : '0;
    assign grant      = grant_q;
    assign busy       = busy_q;

    always_comb begin
        fifo_write_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                fifo_write_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            burst_cnt   <= '0;
            last_winner <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state       <= ST_GRANT;
                        grant_q     <= NUM_REQ'(1) << pick_winner;
                        busy_q      <= 1'b1;
                        burst_cnt   <= '0;
                        last_winner <= pick_winner;
                    end
                end
                ST_GRANT: begin
                    if (release_grant) begin
                        state     <= ST_IDLE;
                        grant_q   <= '0;
                        busy_q    <= 1'b0;
                        burst_cnt <= '0;
                    end else if (xfer) begin
                        burst_cnt <= burst_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - self-checking bench for fifo_write_arbiter
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    ack;
    logic [N-1:0]    grant;
    logic            busy;
    logic            fifo_full;
    logic            fifo_write;
    logic [DW-1:0]   fifo_write_data;

    logic [DW-1:0]   word [N];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner index (-1 = idle), words this grant, last winner.
    int m_owner;
    int m_cnt;
    int m_last;

    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = word[i];
        end
    end

    fifo_write_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req             (req),
        .req_data        (req_data),
        .req_last        (req_last),
        .ack             (ack),
        .grant           (grant),
        .busy            (busy),
        .fifo_full       (fifo_full),
        .fifo_write      (fifo_write),
        .fifo_write_data (fifo_write_data)
    );

    function automatic logic [N-1:0] m_grant();
        if (m_owner < 0) return '0;
        return N'(1) << m_owner;
    endfunction

    function automatic logic m_write();
        if (!reset_n || m_owner < 0) return 1'b0;
        return req[m_owner] && !fifo_full;
    endfunction

    function automatic logic [DW-1:0] m_data();
        if (m_owner < 0) return '0;
        return word[m_owner];
    endfunction

    task automatic model_step();
        int idx;
        if (!reset_n) begin
            m_owner = -1;
            m_cnt   = 0;
            m_last  = N - 1;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (req[idx] && m_owner < 0) begin
                    m_owner = idx;
                end
            end
            if (m_owner >= 0) begin
                m_last = m_owner;
                m_cnt  = 0;
            end
        end else begin
            if (m_write()) begin
                m_cnt = m_cnt + 1;
                if (req_last[m_owner] || m_cnt == MB) m_owner = -1;
            end else if (!req[m_owner]) begin
                m_owner = -1;
            end
        end
    endtask

    task automatic clk_adv();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req       = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) word[i] = '0;
        repeat (2) clk_adv();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req       = 4'b1111;
        req_last  = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) word[i] = DW'(8'h10 + i);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (grant !== 4'b0000 || busy !== 1'b0 || fifo_write !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d grant=%b busy=%b write=%b required 0000/0/0", c, grant, busy, fifo_write);
            end
            clk_adv();
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_release_idle grant=%b required 0000", grant);
        end
        clk_adv();
        @(negedge clk);
        n_checks++;
        if (grant !== 4'b0001 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_grant grant=%b busy=%b required 0001/1", grant, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] eg;
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < N; i++) word[i] = DW'(8'hA0 + i);
        for (int g = 0; g < 5; g++) begin
            eg = 4'b0001 << (g % N);
            @(negedge clk);
            n_checks++;
            if (grant !== 4'b0000 || fifo_write !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_idle g=%0d grant=%b write=%b required 0000/0", g, grant, fifo_write);
            end
            clk_adv();
            for (int b = 0; b < MB; b++) begin
                @(negedge clk);
                n_checks++;
                if (grant !== eg || fifo_write !== 1'b1 || ack !== eg ||
                    fifo_write_data !== DW'(8'hA0 + (g % N))) begin
                    n_fail++;
                    $display("FAIL rr_burst g=%0d b=%0d grant=%b ack=%b write=%b data=%h required %b/%b/1/%h",
                             g, b, grant, ack, fifo_write, fifo_write_data, eg, eg, DW'(8'hA0 + (g % N)));
                end
                clk_adv();
            end
        end
    endtask

    task automatic test_early_last();
        int pulses;
        pulses = 0;
        do_reset();
        req     = 4'b0100;
        word[2] = 8'h51;
        @(negedge clk);
        if (fifo_write === 1'b1) pulses++;
        clk_adv();
        @(negedge clk);
        if (fifo_write === 1'b1) pulses++;
        n_checks++;
        if (grant !== 4'b0100 || fifo_write !== 1'b1 || fifo_write_data !== 8'h51) begin
            n_fail++;
            $display("FAIL last_word1 grant=%b write=%b data=%h required 0100/1/51", grant, fifo_write, fifo_write_data);
        end
        clk_adv();
        word[2]  = 8'h52;
        req_last = 4'b0100;
        @(negedge clk);
        if (fifo_write === 1'b1) pulses++;
        n_checks++;
        if (fifo_write !== 1'b1 || fifo_write_data !== 8'h52) begin
            n_fail++;
            $display("FAIL last_word2 write=%b data=%h required 1/52", fifo_write, fifo_write_data);
        end
        clk_adv();
        req      = '0;
        req_last = '0;
        @(negedge clk);
        n_checks++;
        if (grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL last_release grant=%b required 0000", grant);
        end
        for (int c = 0; c < 3; c++) begin
            if (fifo_write === 1'b1) pulses++;
            clk_adv();
            @(negedge clk);
        end
        n_checks++;
        if (pulses !== 2) begin
            n_fail++;
            $display("FAIL last_pulses count=%0d required 2", pulses);
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        req     = 4'b0010;
        word[1] = 8'h77;
        @(negedge clk);
        clk_adv();
        @(negedge clk);
        n_checks++;
        if (grant !== 4'b0010 || fifo_write !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_first grant=%b write=%b required 0010/1", grant, fifo_write);
        end
        clk_adv();
        fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (grant !== 4'b0010 || fifo_write !== 1'b0 || ack !== 4'b0000) begin
                n_fail++;
                $display("FAIL stall_full c=%0d grant=%b write=%b ack=%b required 0010/0/0000", c, grant, fifo_write, ack);
            end
            clk_adv();
        end
        fifo_full = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (grant !== 4'b0010 || fifo_write !== 1'b1 || ack !== 4'b0010) begin
                n_fail++;
                $display("FAIL stall_resume c=%0d grant=%b write=%b ack=%b required 0010/1/0010", c, grant, fifo_write, ack);
            end
            clk_adv();
        end
        @(negedge clk);
        n_checks++;
        if (grant !== 4'b0000 || fifo_write !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release grant=%b write=%b required 0000/0", grant, fifo_write);
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        req     = 4'b1000;
        word[3] = 8'h33;
        word[0] = 8'h00;
        @(negedge clk);
        clk_adv();
        @(negedge clk);
        n_checks++;
        if (grant !== 4'b1000 || fifo_write !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_first grant=%b write=%b required 1000/1", grant, fifo_write);
        end
        clk_adv();
        req = 4'b0001;
        @(negedge clk);
        n_checks++;
        if (fifo_write !== 1'b0 || ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL wd_drop write=%b ack=%b required 0/0000", fifo_write, ack);
        end
        clk_adv();
        @(negedge clk);
        n_checks++;
        if (grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL wd_idle grant=%b required 0000", grant);
        end
        clk_adv();
        @(negedge clk);
        n_checks++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL wd_next grant=%b required 0001", grant);
        end
    endtask

    task automatic test_random();
        int           seq     [N];
        int           exp_seq [N];
        logic [N-1:0] prev_ack;
        logic [N-1:0] e_grant;
        logic [N-1:0] e_ack;
        logic         e_write;
        logic [DW-1:0] e_data;
        int           id;
        do_reset();
        prev_ack = '0;
        for (int i = 0; i < N; i++) begin
            seq[i]     = 0;
            exp_seq[i] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            reset_n   = ($urandom_range(0, 499) != 0);
            fifo_full = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) begin
                if (req[i] && !prev_ack[i]) begin
                    if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
                end else begin
                    if (prev_ack[i]) seq[i]++;
                    req[i]      = ($urandom_range(0, 3) != 0);
                    req_last[i] = ($urandom_range(0, 3) == 0);
                    word[i]     = {2'(i), 6'(seq[i])};
                end
            end
            @(negedge clk);
            e_grant = m_grant();
            e_write = m_write();
            e_ack   = e_write ? e_grant : '0;
            e_data  = m_data();
            n_checks++;
            if (grant !== e_grant || busy !== (m_owner >= 0)) begin
                n_fail++;
                $display("FAIL rnd_grant c=%0d grant=%b busy=%b required %b/%b", c, grant, busy, e_grant, (m_owner >= 0));
            end
            n_checks++;
            if (fifo_write !== e_write || ack !== e_ack) begin
                n_fail++;
                $display("FAIL rnd_write c=%0d write=%b ack=%b required %b/%b", c, fifo_write, ack, e_write, e_ack);
            end
            n_checks++;
            if (fifo_write_data !== e_data) begin
                n_fail++;
                $display("FAIL rnd_data c=%0d data=%h required %h", c, fifo_write_data, e_data);
            end
            n_checks++;
            if ((fifo_write & fifo_full) !== 1'b0 || !$onehot0(ack)) begin
                n_fail++;
                $display("FAIL rnd_invariant c=%0d write=%b full=%b ack=%b", c, fifo_write, fifo_full, ack);
            end
            if (fifo_write === 1'b1) begin
                id = int'(fifo_write_data[DW-1 -: 2]);
                n_checks++;
                if (fifo_write_data[5:0] !== 6'(exp_seq[id])) begin
                    n_fail++;
                    $display("FAIL rnd_order c=%0d producer=%0d seq=%0d required %0d", c, id, fifo_write_data[5:0], exp_seq[id] % 64);
                end
                exp_seq[id]++;
            end
            prev_ack = e_ack;
            clk_adv();
        end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (exp_seq[i] !== seq[i] + int'(prev_ack[i])) begin
                n_fail++;
                $display("FAIL rnd_count producer=%0d written=%0d required %0d", i, exp_seq[i], seq[i] + int'(prev_ack[i]));
            end
        end
    endtask

    initial begin
        m_owner   = -1;
        m_cnt     = 0;
        m_last    = N - 1;
        reset_n   = 1'b0;
        req       = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) word[i] = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_round_robin();
        test_early_last();
        test_full_stall();
        test_withdraw();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
